// File: rtl/pfq_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pfq_param
// Brief    : Parametrised 8088/8086 instruction prefetch queue (byte FIFO
//            filled by 8/16-bit code fetches, drained one byte by the EU).
// Revision : 1.0
// ============================================================================
module pfq_param #(
  parameter int              BUS_BYTES = 1,
  parameter int              DEPTH     = 4,
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic                         CORE_CLK,
  input  logic                         RESET_n,
  input  logic                         FLUSH,
  input  logic [ADDR_W-1:0]            FLUSH_ADDR,
  output logic                         FETCH_REQ,
  output logic [ADDR_W-1:0]            FETCH_ADDR,
  input  logic                         FETCH_ACK,
  input  logic [ADDR_W-1:0]            FETCH_ACK_ADDR,
  input  logic [8*BUS_BYTES-1:0]       FETCH_DATA,
  input  logic                         PFQ_POP,
  output logic [7:0]                   PFQ_TOP_BYTE,
  output logic                         PFQ_EMPTY,
  output logic [ADDR_W-1:0]            PFQ_ADDR_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   PFQ_COUNT
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [7:0]        r_buf [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_top_addr;

  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_odd;
  logic [1:0]        w_accept_n;
  logic [CNT_W-1:0]  w_room;
  logic              w_accept;
  logic              w_pop;
  logic [7:0]        w_byte0;
  logic [7:0]        w_byte1;
  logic [CNT_W-1:0]  w_count_next;

  // Pointer advance with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH))
      s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  generate
    if (BUS_BYTES == 2) begin : g_bus16
      assign w_odd   = w_fetch_addr[0];
      assign w_byte0 = w_odd ? FETCH_DATA[15:8] : FETCH_DATA[7:0];
      assign w_byte1 = FETCH_DATA[15:8];
    end else begin : g_bus8
      assign w_odd   = 1'b1;
      assign w_byte0 = FETCH_DATA[7:0];
      assign w_byte1 = 8'h00;
    end
  endgenerate

  assign w_fetch_addr = r_top_addr + ADDR_W'(r_count);
  assign w_accept_n   = w_odd ? 2'd1 : 2'd2;
  assign w_room       = C_DEPTH - r_count;

  assign FETCH_ADDR   = w_fetch_addr;
  assign FETCH_REQ    = (w_room >= CNT_W'(w_accept_n));
  assign PFQ_EMPTY    = (r_count == '0);
  assign PFQ_TOP_BYTE = (r_count != '0) ? r_buf[r_rd_ptr] : 8'h00;
  assign PFQ_ADDR_OUT = r_top_addr;
  assign PFQ_COUNT    = r_count;

  // Stale fetches (address mismatch) and acks during flush are dropped here.
  assign w_accept = FETCH_ACK && (FETCH_ACK_ADDR == w_fetch_addr) && FETCH_REQ && !FLUSH;
  assign w_pop    = PFQ_POP && (r_count != '0) && !FLUSH;

  assign w_count_next = r_count
                      + (w_accept ? CNT_W'(w_accept_n) : '0)
                      - (w_pop ? CNT_W'(1) : '0);

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_top_addr <= RESET_IP;
      for (int i = 0; i < DEPTH; i++)
        r_buf[i] <= 8'h00;
    end else if (FLUSH) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_top_addr <= FLUSH_ADDR;
    end else begin
      r_count <= w_count_next;
      if (w_pop) begin
        r_rd_ptr   <= ptr_add(r_rd_ptr, 2'd1);
        r_top_addr <= r_top_addr + ADDR_W'(1);
      end
      if (w_accept) begin
        r_buf[r_wr_ptr] <= w_byte0;
        if (w_accept_n == 2'd2)
          r_buf[ptr_add(r_wr_ptr, 2'd1)] <= w_byte1;
        r_wr_ptr <= ptr_add(r_wr_ptr, w_accept_n);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pfq_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pfq_param
// Brief    : Bench for pfq_param: an 8-bit/depth-4 and a 16-bit/depth-6
//            instance, each compared against a byte-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_pfq_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush      [2];
  logic [15:0] flush_addr [2];
  logic        ack        [2];
  logic [15:0] ack_addr   [2];
  logic [15:0] data       [2];
  logic        pop        [2];

  logic        req   [2];
  logic [15:0] fa    [2];
  logic [7:0]  topb  [2];
  logic        empty [2];
  logic [15:0] ao    [2];
  logic [2:0]  cnt   [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pfq_param #(.BUS_BYTES(1), .DEPTH(4), .ADDR_W(16), .RESET_IP(16'h0000)) u_pfq8 (
    .CORE_CLK(clk), .RESET_n(rst_n), .FLUSH(flush[0]), .FLUSH_ADDR(flush_addr[0]),
    .FETCH_REQ(req[0]), .FETCH_ADDR(fa[0]), .FETCH_ACK(ack[0]),
    .FETCH_ACK_ADDR(ack_addr[0]), .FETCH_DATA(data[0][7:0]), .PFQ_POP(pop[0]),
    .PFQ_TOP_BYTE(topb[0]), .PFQ_EMPTY(empty[0]), .PFQ_ADDR_OUT(ao[0]),
    .PFQ_COUNT(cnt[0]));

  pfq_param #(.BUS_BYTES(2), .DEPTH(6), .ADDR_W(16), .RESET_IP(16'h0000)) u_pfq16 (
    .CORE_CLK(clk), .RESET_n(rst_n), .FLUSH(flush[1]), .FLUSH_ADDR(flush_addr[1]),
    .FETCH_REQ(req[1]), .FETCH_ADDR(fa[1]), .FETCH_ACK(ack[1]),
    .FETCH_ACK_ADDR(ack_addr[1]), .FETCH_DATA(data[1]), .PFQ_POP(pop[1]),
    .PFQ_TOP_BYTE(topb[1]), .PFQ_EMPTY(empty[1]), .PFQ_ADDR_OUT(ao[1]),
    .PFQ_COUNT(cnt[1]));

  // Reference model: an ordered byte queue plus the offset of its head byte.
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [15:0] mtop [2];
  int          mbb  [2] = '{1, 2};
  int          mdep [2] = '{4, 6};

  function automatic int msize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] mfront(int k);
    if (msize(k) == 0) return 8'h00;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void mpush(int k, logic [7:0] b);
    if (k == 0) q0.push_back(b); else q1.push_back(b);
  endfunction

  function automatic void mpopf(int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic logic [15:0] mfa(int k);
    return mtop[k] + 16'(msize(k));
  endfunction

  function automatic int mneed(int k);
    logic [15:0] a;
    a = mfa(k);
    return (mbb[k] == 1 || a[0]) ? 1 : 2;
  endfunction

  function automatic logic mreq(int k);
    return (mdep[k] - msize(k)) >= mneed(k);
  endfunction

  task automatic mreset();
    q0.delete();
    q1.delete();
    mtop[0] = 16'h0000;
    mtop[1] = 16'h0000;
  endtask

  task automatic model_step(int k);
    logic [15:0] a;
    int          need;
    logic        acc;
    if (flush[k]) begin
      if (k == 0) q0.delete(); else q1.delete();
      mtop[k] = flush_addr[k];
    end else begin
      a    = mfa(k);
      need = mneed(k);
      acc  = ack[k] && (ack_addr[k] == a) && mreq(k);
      if (pop[k] && msize(k) > 0) begin
        mpopf(k);
        mtop[k] = mtop[k] + 16'd1;
      end
      if (acc) begin
        if (need == 2) begin
          mpush(k, data[k][7:0]);
          mpush(k, data[k][15:8]);
        end else if (mbb[k] == 2) begin
          mpush(k, data[k][15:8]);
        end else begin
          mpush(k, data[k][7:0]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h @%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("count",      k, 32'(cnt[k]),   32'(msize(k)));
      chk("empty",      k, 32'(empty[k]), 32'(msize(k) == 0));
      chk("top_byte",   k, 32'(topb[k]),  32'(mfront(k)));
      chk("addr_out",   k, 32'(ao[k]),    32'(mtop[k]));
      chk("fetch_addr", k, 32'(fa[k]),    32'(mfa(k)));
      chk("fetch_req",  k, 32'(req[k]),   32'(mreq(k)));
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; flush_addr[k] = 16'h0; ack[k] = 1'b0;
      ack_addr[k] = 16'h0; data[k] = 16'h0; pop[k] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic do_ack(int k, logic [15:0] a, logic [15:0] d);
    ack[k] = 1'b1; ack_addr[k] = a; data[k] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    mreset();
    #12;
    check_all();
    rst_n = 1'b1;

    // 8-bit instance: fill to full, then drain in order, then pop while empty.
    for (int i = 0; i < 4; i++) begin
      do_ack(0, 16'(i), 16'h00A0 + 16'(i));
      cycle();
    end
    idle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      pop[0] = 1'b1;
      cycle();
    end
    idle();

    // 16-bit instance: odd-address flush takes one byte, then word fetches.
    flush[1] = 1'b1; flush_addr[1] = 16'h0011;
    cycle();
    idle();
    do_ack(1, 16'h0011, 16'hBBAA); cycle();
    do_ack(1, 16'h0012, 16'hDDCC); cycle();
    do_ack(1, 16'h0014, 16'h1122); cycle();
    idle(); cycle();
    pop[1] = 1'b1; do_ack(1, 16'h0016, 16'h3344); cycle();
    idle();
    do_ack(1, 16'h0016, 16'h3344); cycle();
    idle(); cycle();

    // Stale fetch from before a flush is dropped.
    do_ack(1, 16'h0042, 16'hEEEE); flush[1] = 1'b1; flush_addr[1] = 16'h0100; cycle();
    idle();
    do_ack(1, 16'h0042, 16'hEEEE); cycle();
    do_ack(1, 16'h0100, 16'h5566); cycle();
    idle();

    // Offset wrap on the 8-bit instance.
    flush[0] = 1'b1; flush_addr[0] = 16'hFFFF; cycle();
    idle();
    do_ack(0, 16'hFFFF, 16'h0077); cycle();
    do_ack(0, 16'h0000, 16'h0088); cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      pop[0] = 1'b1;
      cycle();
    end
    idle();

    // Asynchronous reset mid-stream with three bytes held.
    for (int i = 0; i < 3; i++) begin
      do_ack(0, mfa(0), 16'h00C0 + 16'(i));
      cycle();
    end
    idle();
    @(posedge clk);
    model_step(0); model_step(1);
    #3;
    rst_n = 1'b0;
    #1;
    mreset();
    check_all();
    #2;
    rst_n = 1'b1;

    // Randomised traffic, including stale acks and flushes near the wrap point.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        flush[k]      = ($urandom_range(0, 31) == 0);
        flush_addr[k] = ($urandom_range(0, 3) == 0) ? (16'hFFFD + 16'($urandom_range(0, 3)))
                                                   : 16'($urandom);
        ack[k]        = ($urandom_range(0, 1) == 1);
        ack_addr[k]   = ($urandom_range(0, 3) != 0) ? mfa(k) : 16'($urandom);
        data[k]       = 16'($urandom);
        pop[k]        = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pfq_param.md
Name: pfq_param

Overview:
- Parametrised instruction prefetch queue for the 8088/8086 core family.
- Sits between the bus interface unit (fills it from code fetches) and the execution unit (consumes opcode bytes).
- Generalises the fixed 8088 4-byte/8-bit queue to configurable depth and 8- or 16-bit fetch width, with odd-address alignment, flush-with-reload and stale-fetch discard.

Parameters:
- BUS_BYTES, 1, bytes per fetch: 1 = 8088 style, 2 = 8086 style. Legal values are 1 and 2 only.
- DEPTH, 4, queue capacity in bytes. Legal range is 2..16 and DEPTH >= BUS_BYTES.
- ADDR_W, 16, width of the code offset (IP).
- RESET_IP, 16'h0000, top-of-queue offset after reset.

Ports:
- CORE_CLK  input  1  core clock; all state updates on rising edge.
- RESET_n  input  1  asynchronous active-low reset.
- FLUSH  input  1  discard queue contents and restart at FLUSH_ADDR.
- FLUSH_ADDR  input  ADDR_W  new top-of-queue offset.
- FETCH_REQ  output  1  queue has room for the next fetch.
- FETCH_ADDR  output  ADDR_W  byte offset of the next byte to fetch.
- FETCH_ACK  input  1  one-cycle pulse: fetch data valid.
- FETCH_ACK_ADDR  input  ADDR_W  FETCH_ADDR value the returning fetch was issued with.
- FETCH_DATA  input  8*BUS_BYTES  fetched data; byte 0 = even/low address.
- PFQ_POP  input  1  EU consumes the top byte.
- PFQ_TOP_BYTE  output  8  byte at head of queue.
- PFQ_EMPTY  output  1  queue holds no bytes.
- PFQ_ADDR_OUT  output  ADDR_W  offset of PFQ_TOP_BYTE.
- PFQ_COUNT  output  clog2(DEPTH+1)  bytes held.

Behaviour:
- Storage: DEPTH-entry byte circular buffer with rd_ptr, wr_ptr and count. Pointers wrap at DEPTH, which need not be a power of 2.
- Reset (async, RESET_n low):
  - count=0, pointers=0, PFQ_ADDR_OUT=RESET_IP.
  - PFQ_EMPTY=1, PFQ_TOP_BYTE=8'h00, FETCH_REQ=1, FETCH_ADDR=RESET_IP.
  - Buffer contents cleared to 0.
- Derived (combinational from registers):
  - FETCH_ADDR = PFQ_ADDR_OUT + count, mod 2^ADDR_W.
  - accept_n = 1 if BUS_BYTES=1 or FETCH_ADDR[0]=1; otherwise 2.
  - FETCH_REQ = (DEPTH - count) >= accept_n.
  - PFQ_EMPTY = (count==0).
  - PFQ_TOP_BYTE = buf[rd_ptr] when count != 0, else 8'h00.
- Fetch accept:
  - A fetch is accepted on a cycle when FETCH_ACK=1, FETCH_ACK_ADDR==FETCH_ADDR, FETCH_REQ=1 and FLUSH=0.
  - Any other FETCH_ACK is dropped silently with no state change. This covers stale fetches issued before a flush.
- Bytes written on accept:
  - BUS_BYTES=1: FETCH_DATA[7:0].
  - BUS_BYTES=2, even FETCH_ADDR: FETCH_DATA[7:0], then [15:8].
  - BUS_BYTES=2, odd FETCH_ADDR: only FETCH_DATA[15:8] is written; the low byte is discarded.
  - wr_ptr advances by accept_n.
- Pop: PFQ_POP with count != 0 advances rd_ptr by 1 and increments PFQ_ADDR_OUT by 1, wrapping at 2^ADDR_W. PFQ_POP while empty is ignored.
- Simultaneous pop and accept in one cycle: count_next = count + accept_n - 1. accept_n is evaluated on pre-pop state, so a full queue cannot accept in the same cycle it pops.
- Flush has highest priority:
  - count=0 and rd_ptr=wr_ptr (reset to 0); PFQ_ADDR_OUT=FLUSH_ADDR on the next edge.
  - Concurrent POP and FETCH_ACK are ignored.
  - The first fetch after a flush to an odd address accepts a single byte (BUS_BYTES=2).
- Latency: an accepted byte is visible at PFQ_TOP_BYTE on the cycle after the FETCH_ACK edge. No bypass.
- Offset wrap: FETCH_ADDR and PFQ_ADDR_OUT wrap modulo 2^ADDR_W. Byte order across the wrap is preserved.
- Invariant: 0 <= count <= DEPTH at all times.

Test Plan:
- Reset, BUS_BYTES=1, DEPTH=4 → FETCH_ADDR=0, FETCH_REQ=1, PFQ_EMPTY=1. Acks at 0,1,2,3 with data A0..A3 → PFQ_COUNT=4, FETCH_REQ=0, top=A0. Four pops return A0..A3 at addrs 0..3, then PFQ_EMPTY=1.
- BUS_BYTES=2, DEPTH=6:
  - FLUSH to 16'h0011 → FETCH_ADDR=0011, FETCH_REQ=1.
  - Ack data 16'hBBAA at 0011 → count=1, top=BB.
  - Next FETCH_ADDR=0012; ack 16'hDDCC → count=3, bytes BB,CC,DD.
- BUS_BYTES=2, DEPTH=6, count=5 → FETCH_ADDR even, FETCH_REQ=0. Pop and ack asserted together are both handled; the ack is dropped because FETCH_REQ=0 → count=4. The next ack is accepted → count=6.
- Flush to 16'h0100 while a fetch issued at 16'h0042 is outstanding. Ack with FETCH_ACK_ADDR=0042 → dropped, count=0. Ack at 0100 → accepted.
- Wrap: FLUSH to 16'hFFFF, BUS_BYTES=1. Acks at FFFF then 0000 → pops return addrs FFFF, 0000 in order. Pop while empty → no change.
- Assert RESET_n low mid-stream with count=3 → all outputs return to reset values asynchronously, before the next clock edge.
